// File: rtl/riscpu_pkg.sv
// Shared definitions for the fetch/issue path:
// opcodes, instruction field positions and fetch states.
package riscpu_pkg;

    localparam logic [7:0] OP_LDD   = 8'h01;
    localparam logic [7:0] OP_LDI   = 8'h02;
    localparam logic [7:0] OP_LDIMM = 8'h03;
    localparam logic [7:0] OP_ST    = 8'h04;
    localparam logic [7:0] OP_STI   = 8'h05;
    localparam logic [7:0] OP_ADD   = 8'h06;
    localparam logic [7:0] OP_SUB   = 8'h07;
    localparam logic [7:0] OP_AND   = 8'h08;
    localparam logic [7:0] OP_OR    = 8'h09;
    localparam logic [7:0] OP_XOR   = 8'h0A;
    localparam logic [7:0] OP_SHL   = 8'h0B;
    localparam logic [7:0] OP_SHR   = 8'h0C;
    localparam logic [7:0] OP_EQ    = 8'h0D;
    localparam logic [7:0] OP_JMP   = 8'h0E;
    localparam logic [7:0] OP_JNE   = 8'h0F;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    localparam int OPC_LSB = 24;
    localparam int RD_LSB  = 20;
    localparam int RS1_LSB = 16;
    localparam int RS2_LSB = 12;
    localparam int IMM_LSB = 0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus: program memory port, register-file
// compare input and the issue handshake to execute.
interface instruction_fetch_unit_if #(
    parameter int ADDR_W  = 12,
    parameter int INSTR_W = 32
);
    logic [ADDR_W-1:0]  program_addr;
    logic [INSTR_W-1:0] instruction;
    logic               cmp_ne;
    logic               if_valid;
    logic               ex_ready;
    logic [7:0]         opcode;
    logic [3:0]         rd;
    logic [3:0]         rs1;
    logic [3:0]         rs2;
    logic [11:0]        imm;

    modport master (
        output program_addr, if_valid,
        output opcode, rd, rs1, rs2, imm,
        input  instruction, cmp_ne, ex_ready
    );

    modport slave (
        input  program_addr, if_valid,
        input  opcode, rd, rs1, rs2, imm,
        output instruction, cmp_ne, ex_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch/issue sequencer: holds PC and IR, offers
// datapath ops to execute, resolves jmp/jne/halt here.
module instruction_fetch_unit
    import riscpu_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 32
) (
    input  logic                      clk_70_mhz,
    input  logic                      rst_n,
    input  logic                      start,
    instruction_fetch_unit_if.master  bus,
    output logic                      halted,
    output logic                      illegal_op,
    output logic [CNT_W-1:0]          instr_count
);

    logic [1:0]         state;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] ir;
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  target;
    logic               is_exec;
    logic               is_jmp;
    logic               is_jne;
    logic               is_halt;

    assign bus.opcode = ir[OPC_LSB +: 8];
    assign bus.rd     = ir[RD_LSB  +: 4];
    assign bus.rs1    = ir[RS1_LSB +: 4];
    assign bus.rs2    = ir[RS2_LSB +: 4];
    assign bus.imm    = ir[IMM_LSB +: 12];

    assign bus.program_addr = pc;

    assign is_exec = (bus.opcode >= OP_LDD) &&
                     (bus.opcode <= OP_EQ);
    assign is_jmp  = bus.opcode == OP_JMP;
    assign is_jne  = bus.opcode == OP_JNE;
    assign is_halt = bus.opcode == OP_HALT;

    assign pc_inc = pc + ADDR_W'(1);
    assign target = ADDR_W'(bus.imm);

    assign bus.if_valid = (state == ST_ISSUE) && is_exec;

    // Sequencer: IDLE -> FETCH -> ISSUE loop, HALT is terminal.
    always_ff @(posedge clk_70_mhz or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= '0;
            ir          <= '0;
            halted      <= 1'b0;
            illegal_op  <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    pc <= '0;
                    if (start)
                        state <= ST_FETCH;
                end
                ST_FETCH: begin
                    ir    <= bus.instruction;
                    state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    unique case (1'b1)
                        is_exec: begin
                            if (bus.ex_ready) begin
                                pc          <= pc_inc;
                                instr_count <= instr_count + CNT_W'(1);
                                state       <= ST_FETCH;
                            end
                        end
                        is_jmp: begin
                            pc          <= target;
                            instr_count <= instr_count + CNT_W'(1);
                            state       <= ST_FETCH;
                        end
                        is_jne: begin
                            pc          <= bus.cmp_ne ? target : pc_inc;
                            instr_count <= instr_count + CNT_W'(1);
                            state       <= ST_FETCH;
                        end
                        is_halt: begin
                            halted      <= 1'b1;
                            instr_count <= instr_count + CNT_W'(1);
                            state       <= ST_HALT;
                        end
                        default: begin
                            illegal_op <= 1'b1;
                            pc         <= pc_inc;
                            state      <= ST_FETCH;
                        end
                    endcase
                end
                default: begin
                    state <= ST_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: issue,
// stall, jumps, jne, halt, illegal op and async reset.
module tb_instruction_fetch_unit;

    logic        clk_70_mhz = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cmp_ne = 1'b0;
    logic        ex_ready = 1'b0;
    logic        halted;
    logic        illegal_op;
    logic [31:0] instr_count;
    logic [31:0] mem [0:4095];

    int checks = 0;
    int passes = 0;

    instruction_fetch_unit_if bus ();

    assign bus.instruction = mem[bus.program_addr];
    assign bus.cmp_ne      = cmp_ne;
    assign bus.ex_ready    = ex_ready;

    instruction_fetch_unit dut (
        .clk_70_mhz  (clk_70_mhz),
        .rst_n       (rst_n),
        .start       (start),
        .bus         (bus),
        .halted      (halted),
        .illegal_op  (illegal_op),
        .instr_count (instr_count)
    );

    always #7 clk_70_mhz = ~clk_70_mhz;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h",
                    tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_70_mhz);
        @(negedge clk_70_mhz);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[0]    = 32'h03000003;
        mem[1]    = 32'h0310000A;
        mem[2]    = 32'h0E00000A;
        mem[10]   = 32'h0E000FFC;
        mem[4092] = 32'h0E000FFF;
        mem[4095] = 32'h06400000;
        mem[22]   = 32'h0E000017;
        mem[23]   = 32'h0F002016;
        mem[24]   = 32'hFF000000;

        // reset state
        #3;
        check("rst_addr", 32'(bus.program_addr), 32'h0);
        check("rst_valid", 32'(bus.if_valid), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_illegal", 32'(illegal_op), 32'h0);
        check("rst_count", instr_count, 32'h0);
        check("rst_opcode", 32'(bus.opcode), 32'h0);
        check("rst_imm", 32'(bus.imm), 32'h0);
        @(negedge clk_70_mhz);
        rst_n = 1'b1;
        start = 1'b1;
        ex_ready = 1'b1;

        // test 1: first issue after start
        tick();
        check("t1_idle_valid", 32'(bus.if_valid), 32'h0);
        check("t1_addr0", 32'(bus.program_addr), 32'h0);
        tick();
        check("t1_valid", 32'(bus.if_valid), 32'h1);
        check("t1_opcode", 32'(bus.opcode), 32'h03);
        check("t1_rd", 32'(bus.rd), 32'h0);
        check("t1_imm", 32'(bus.imm), 32'h003);
        tick();
        check("t1_addr1", 32'(bus.program_addr), 32'h1);
        check("t1_count", instr_count, 32'h1);
        check("t1_fetch_valid", 32'(bus.if_valid), 32'h0);

        // test 2: stall for five cycles
        ex_ready = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_valid", 32'(bus.if_valid), 32'h1);
            check("t2_hold_opcode", 32'(bus.opcode), 32'h03);
            check("t2_hold_rd", 32'(bus.rd), 32'h1);
            check("t2_hold_imm", 32'(bus.imm), 32'h00A);
            check("t2_hold_pc", 32'(bus.program_addr), 32'h1);
            check("t2_hold_count", instr_count, 32'h1);
        end
        ex_ready = 1'b1;
        tick();
        check("t2_pc", 32'(bus.program_addr), 32'h2);
        check("t2_count", instr_count, 32'h2);

        // test 3: jumps and PC wrap
        tick();
        check("t3_jmp_valid", 32'(bus.if_valid), 32'h0);
        check("t3_jmp_opcode", 32'(bus.opcode), 32'h0E);
        tick();
        check("t3_pc10", 32'(bus.program_addr), 32'd10);
        check("t3_count3", instr_count, 32'd3);
        tick();
        check("t3_jmp2_valid", 32'(bus.if_valid), 32'h0);
        tick();
        check("t3_pcffc", 32'(bus.program_addr), 32'hFFC);
        check("t3_count4", instr_count, 32'd4);
        tick();
        tick();
        check("t3_pcfff", 32'(bus.program_addr), 32'hFFF);
        tick();
        check("t3_add_valid", 32'(bus.if_valid), 32'h1);
        check("t3_add_rd", 32'(bus.rd), 32'h4);
        tick();
        check("t3_wrap", 32'(bus.program_addr), 32'h0);
        check("t3_count6", instr_count, 32'd6);

        // test 4: jne taken then not taken
        mem[0] = 32'h0E000017;
        tick();
        tick();
        check("t4_pc23", 32'(bus.program_addr), 32'd23);
        cmp_ne = 1'b1;
        tick();
        check("t4_jne_valid", 32'(bus.if_valid), 32'h0);
        tick();
        check("t4_taken", 32'(bus.program_addr), 32'd22);
        check("t4_count8", instr_count, 32'd8);
        tick();
        tick();
        check("t4_back23", 32'(bus.program_addr), 32'd23);
        cmp_ne = 1'b0;
        tick();
        check("t4_jne2_valid", 32'(bus.if_valid), 32'h0);
        tick();
        check("t4_not_taken", 32'(bus.program_addr), 32'd24);
        check("t4_count10", instr_count, 32'd10);

        // test 5: halt is terminal
        tick();
        check("t5_halt_valid", 32'(bus.if_valid), 32'h0);
        check("t5_pre_halted", 32'(halted), 32'h0);
        tick();
        check("t5_halted", 32'(halted), 32'h1);
        check("t5_count11", instr_count, 32'd11);
        for (int i = 0; i < 20; i++) begin
            start = ~start;
            tick();
            check("t5_frz_addr", 32'(bus.program_addr), 32'd24);
            check("t5_frz_valid", 32'(bus.if_valid), 32'h0);
            check("t5_frz_halted", 32'(halted), 32'h1);
            check("t5_frz_count", instr_count, 32'd11);
        end
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check("t5_rst_halted", 32'(halted), 32'h0);
        check("t5_rst_addr", 32'(bus.program_addr), 32'h0);

        // test 6: illegal opcode, then reset mid-issue
        mem[0] = 32'h0E000005;
        mem[5] = 32'h20000000;
        mem[6] = 32'h06000000;
        @(negedge clk_70_mhz);
        rst_n = 1'b1;
        start = 1'b1;
        ex_ready = 1'b1;
        tick();
        tick();
        tick();
        check("t6_pc5", 32'(bus.program_addr), 32'd5);
        tick();
        check("t6_ill_valid", 32'(bus.if_valid), 32'h0);
        check("t6_ill_pre", 32'(illegal_op), 32'h0);
        tick();
        check("t6_illegal", 32'(illegal_op), 32'h1);
        check("t6_pc6", 32'(bus.program_addr), 32'd6);
        check("t6_nocount", instr_count, 32'd1);
        ex_ready = 1'b0;
        tick();
        check("t6_add_valid", 32'(bus.if_valid), 32'h1);
        tick();
        check("t6_still_valid", 32'(bus.if_valid), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(bus.if_valid), 32'h0);
        check("t6_async_illegal", 32'(illegal_op), 32'h0);
        check("t6_async_count", instr_count, 32'h0);
        check("t6_async_addr", 32'(bus.program_addr), 32'h0);
        check("t6_async_opcode", 32'(bus.opcode), 32'h0);
        tick();
        check("t6_rst_hold", 32'(bus.if_valid), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Sequencer that sits between the program counter and the program memory on one side, and the execute/register-file stage on the other.
- Holds the PC, drives the program memory address, and latches the returned instruction into an instruction register (IR).
- Decodes the instruction fields and hands each non-control instruction to execute over a valid/ready handshake.
- Resolves jump (0x0E), jump-if-not-equal (0x0F) and halt (0xFF) locally.

Parameters:
- ADDR_W, 12, program memory address width; PC width.
- INSTR_W, 32, instruction width.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk_70_mhz  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  level; leaves IDLE when high.
- program_addr  out  ADDR_W  address to program memory (async read).
- instruction  in  INSTR_W  data from program memory.
- cmp_ne  in  1  from register file: reg[rs1] != reg[rs2], computed combinationally from rs1/rs2 below.
- ex_ready  in  1  execute stage can accept this cycle.
- if_valid  out  1  IR holds an instruction offered to execute.
- opcode  out  8  IR[31:24].
- rd  out  4  IR[23:20].
- rs1  out  4  IR[19:16].
- rs2  out  4  IR[15:12].
- imm  out  12  IR[11:0]; also used as the data-memory address.
- halted  out  1  high once a halt has been taken.
- illegal_op  out  1  sticky; set on an undefined opcode.
- instr_count  out  CNT_W  count of instructions retired.

Behaviour:
- Async reset (rst_n=0):
  - pc=0, IR=0, state=IDLE.
  - program_addr=0, if_valid=0, halted=0, illegal_op=0, instr_count=0.
  - Field outputs read 0.
  - Takes effect immediately in any state, including mid-handshake; no partial retire occurs.
- program_addr is always pc (registered). opcode, rd, rs1, rs2 and imm are always slices of the IR.
- State IDLE: pc held at 0. start=1 -> FETCH.
- State FETCH (1 cycle): IR <= instruction. Go to ISSUE.
- State ISSUE, by IR opcode:
  - 0x01–0x0D (load/store/ALU/compare):
    - if_valid=1.
    - On if_valid&&ex_ready: pc<=pc+1, instr_count++, go to FETCH.
    - While ex_ready=0: IR, pc and if_valid are held stable.
  - 0x0E jump: if_valid stays 0. pc<=imm, instr_count++, go to FETCH (1 cycle in ISSUE).
  - 0x0F jne:
    - if_valid stays 0.
    - pc<=cmp_ne ? imm : pc+1, sampled in the single ISSUE cycle.
    - instr_count++, go to FETCH.
  - 0xFF halt: if_valid stays 0, halted<=1, instr_count++, go to HALT.
  - Any other opcode (0x00, 0x10–0xFE): not offered. illegal_op<=1 (sticky), pc<=pc+1, no count, go to FETCH.
- State HALT:
  - Terminal until rst_n. pc and IR frozen, if_valid=0.
  - start is ignored.
- Throughput: at most 1 instruction per 2 cycles (FETCH+ISSUE). Latency start->first if_valid = 2 cycles.
- Wrap-around:
  - pc+1 at 4095 gives 0 (modulo 2^ADDR_W).
  - A jump target is imm truncated to ADDR_W.
- instr_count wraps modulo 2^CNT_W.
- start deasserted after leaving IDLE: no effect.
- cmp_ne is only sampled in ISSUE with opcode 0x0F; it is a don't-care otherwise.

Decomposition:
- Shared package riscpu_pkg:
  - opcode localparams (OP_LDD=0x01, OP_LDI=0x02, OP_LDIMM=0x03, OP_ST=0x04, OP_STI=0x05, OP_ADD=0x06 … OP_EQ=0x0D, OP_JMP=0x0E, OP_JNE=0x0F, OP_HALT=0xFF);
  - field bit positions;
  - fetch state encoding (IDLE, FETCH, ISSUE, HALT).
- No sub-module: field slicing and the opcode classify are a few assigns in this block.

Test Plan:
1. Reset; memory[0]=0x03000003; start=1, ex_ready=1.
   -> program_addr=0 then if_valid at cycle 2 with opcode=0x03, rd=0, imm=0x003; next program_addr=1; instr_count=1.
2. Issue memory[1]=0x0310000A with ex_ready=0 for 5 cycles, then 1.
   -> if_valid held 5 cycles, opcode/rd/imm stable, pc=1 throughout; after the accept pc=2 and instr_count increments once.
3. memory[10]=0x0E000FFC, then memory[4095]=0x06400000.
   -> no if_valid for the jump; next program_addr=0xFFC; after 4095 issues, program_addr=0.
4. memory[23]=0x0F002016.
   -> cmp_ne=1 gives next program_addr=22; cmp_ne=0 gives 24; if_valid never asserted for it.
5. memory[24]=0xFF000000.
   -> halted=1, if_valid=0, program_addr frozen at 24 for 20 cycles despite start toggling; rst_n low clears halted and gives program_addr=0.
6. Undefined opcode 0x20 at pc 5, then rst_n pulsed low mid-ISSUE of a valid op.
   -> illegal_op=1 and pc goes to 6 with no if_valid; during reset if_valid, illegal_op and instr_count are 0 asynchronously, before the next edge.
